// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package Ins_def;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_pkt_t;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bundle: imem request/response, redirect and decode channels.
interface ifetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid, imem_addr,
        output inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        input  inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/ifetch_unit_fifo.sv
// Synchronous FIFO with flush; used for prefetch packets and request PCs.
module ifetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch, prefetch
// buffering and redirect with squash of in-flight responses.
module ifetch_unit
    import Ins_def::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic           clk,
    input logic           reset,
    ifetch_unit_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    fetch_state_e  state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] pf_count;
    logic [CW-1:0] pc_count;
    logic          pf_empty;
    logic          pf_full;
    logic          pc_empty;
    logic          pc_full;
    logic [31:0]   pc_head;
    fetch_pkt_t    pf_in;
    fetch_pkt_t    pf_head;
    logic [CW:0]   credit;
    logic          req_fire;
    logic          rsp_keep;
    logic          unused_flags;

    // Outstanding requests plus buffered entries never exceed DEPTH,
    // so neither FIFO can overflow.
    assign credit   = {1'b0, outstanding} + {1'b0, pf_count};
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_keep = bus.imem_rsp_valid && (drop_cnt == '0)
                      && !bus.redirect_valid;
    assign pf_in    = '{pc: pc_head, instr: bus.imem_rsp_data};

    assign bus.imem_req_valid = (state == RUN) && !bus.redirect_valid
                                && (credit < CAP);
    assign bus.imem_addr      = fetch_pc;
    assign bus.inst_valid     = !pf_empty;
    assign bus.inst_data      = pf_empty ? '0 : pf_head.instr;
    assign bus.inst_pc        = pf_empty ? '0 : pf_head.pc;

    assign unused_flags = ^{pc_count, pc_empty, pc_full, pf_full};

    ifetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_pf_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (rsp_keep),
        .pop   (bus.inst_valid && bus.inst_ready),
        .flush (bus.redirect_valid),
        .din   (pf_in),
        .dout  (pf_head),
        .count (pf_count),
        .empty (pf_empty),
        .full  (pf_full)
    );

    // Stale PCs stay queued so dropped responses still pop their own entry.
    ifetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_pc_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (req_fire),
        .pop   (bus.imem_rsp_valid),
        .flush (1'b0),
        .din   (fetch_pc),
        .dout  (pc_head),
        .count (pc_count),
        .empty (pc_empty),
        .full  (pc_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            unique case (state)
                BOOT: state <= RUN;
                RUN:  state <= RUN;
            endcase
            outstanding <= outstanding + CW'(req_fire)
                           - CW'(bus.imem_rsp_valid);
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc & ~32'h3;
                drop_cnt <= outstanding - CW'(bus.imem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
                if (bus.imem_rsp_valid && drop_cnt != '0)
                    drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: epoch-tagged memory model, directed
// scenarios and randomized redirect/backpressure traffic.
module tb_ifetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } pkt_t;

    logic clk = 0;
    logic reset;
    ifetch_unit_if bus();

    ifetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          rel_cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat = 1;
    int          epoch = 0;
    int          nacc = 0;
    int          first_acc_rel = -1;
    logic        triple = 0;
    logic [31:0] nfetch = RESET_PC;
    req_t        pend[$];
    pkt_t        exp_q[$];
    logic [31:0] hs_pcs[$];
    int          hs_rel[$];
    req_t        mr;
    pkt_t        mp;
    logic        erv;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] pc_at(input int i);
        if (i < hs_pcs.size()) return hs_pcs[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int rel_at(input int i);
        if (i < hs_rel.size()) return hs_rel[i];
        return -1;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            2: return 32'($urandom_range(0, 255));
            default: return 32'h0000_0100;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory: in-order responses once each request's latency has elapsed.
    always @(posedge clk) begin
        #1;
        if (reset && pend.size() != 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mdata(pend[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
    end

    // Monitor and reference model, evaluated mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            erv = (cyc - rel_cyc >= 1) && !bus.redirect_valid
                  && (pend.size() + exp_q.size() < DEPTH);
            chk("req_valid", 32'(bus.imem_req_valid), 32'(erv));
            chk("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
            if (bus.inst_valid && exp_q.size() != 0) begin
                chk("inst_pc", bus.inst_pc, exp_q[0].pc);
                chk("inst_data", bus.inst_data, exp_q[0].instr);
                if (bus.inst_ready) begin
                    void'(exp_q.pop_front());
                    hs_pcs.push_back(bus.inst_pc);
                    hs_rel.push_back(cyc - rel_cyc + 1);
                end
            end
            if (bus.redirect_valid && bus.imem_rsp_valid
                && bus.inst_valid && bus.inst_ready)
                triple = 1'b1;
            if (bus.imem_rsp_valid && pend.size() != 0) begin
                mr = pend.pop_front();
                if (mr.epoch == epoch && !bus.redirect_valid) begin
                    mp.pc    = mr.addr;
                    mp.instr = mdata(mr.addr);
                    exp_q.push_back(mp);
                end
            end
            if (bus.redirect_valid) begin
                exp_q.delete();
                epoch++;
                nfetch = bus.redirect_pc & ~32'h3;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                chk("imem_addr", bus.imem_addr, nfetch);
                if (first_acc_rel < 0) first_acc_rel = cyc - rel_cyc + 1;
                mr.addr  = nfetch;
                mr.epoch = epoch;
                mr.due   = cyc + lat;
                pend.push_back(mr);
                nfetch += 32'd4;
                nacc++;
            end
        end
    end

    task automatic drive(input logic rr, input logic ir, input logic rv,
                         input logic [31:0] rp);
        bus.imem_req_ready = rr;
        bus.inst_ready     = ir;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b0;
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_imem_addr", bus.imem_addr, RESET_PC);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst_data", bus.inst_data, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        exp_q.delete();
        pend.delete();
        hs_pcs.delete();
        hs_rel.delete();
        epoch = 0;
        nacc = 0;
        first_acc_rel = -1;
        triple = 1'b0;
        nfetch = RESET_PC;
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        rel_cyc = cyc;
    endtask

    int rpct[4] = '{100, 70, 50, 85};
    int ipct[4] = '{100, 60, 30, 90};

    initial begin
        reset = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        @(posedge clk);
        #1;

        // Reset release, zero-wait memory, full-rate decode.
        lat = 1;
        do_reset();
        repeat (14) drive(1, 1, 0, 0);
        chk("first_req_cycle", 32'(first_acc_rel), 32'd2);
        chk("first_inst_cycle", 32'(rel_at(0)), 32'd4);
        chk("stream_count", 32'(hs_pcs.size()), 32'd11);
        chk("stream_pc10", pc_at(10), 32'h0000_0028);

        // Decode stalled: credit limit caps requests at DEPTH.
        do_reset();
        repeat (20) drive(1, 0, 0, 0);
        chk("stall_requests", 32'(nacc), 32'(DEPTH));
        chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("stall_inst_pc", bus.inst_pc, 32'd0);
        chk("stall_inst_data", bus.inst_data, mdata(32'd0));

        // Two in flight on a slow memory, then redirect to an unaligned pc.
        lat = 3;
        do_reset();
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        chk("inflight_two", 32'(pend.size()), 32'd2);
        drive(0, 1, 1, 32'h0000_0103);
        repeat (12) drive(1, 1, 0, 0);
        chk("redir_first_pc", pc_at(0), 32'h0000_0100);

        // Redirect coinciding with a response and a decode handshake.
        lat = 1;
        do_reset();
        repeat (7) drive(1, 1, 0, 0);
        drive(1, 1, 1, 32'h0000_2000);
        repeat (8) drive(1, 1, 0, 0);
        chk("triple_seen", 32'(triple), 32'd1);
        chk("triple_last_old", pc_at(4), 32'h0000_0010);
        chk("triple_first_new", pc_at(5), 32'h0000_2000);

        // Address wrap at the top of memory.
        do_reset();
        drive(1, 1, 0, 0);
        drive(1, 1, 1, 32'hFFFF_FFF8);
        repeat (10) drive(1, 1, 0, 0);
        chk("wrap_pc0", pc_at(0), 32'hFFFF_FFF8);
        chk("wrap_pc1", pc_at(1), 32'hFFFF_FFFC);
        chk("wrap_pc2", pc_at(2), 32'h0000_0000);

        // Reset with three buffered entries and one outstanding.
        do_reset();
        repeat (5) drive(1, 0, 0, 0);
        chk("pre_buffered", 32'(exp_q.size()), 32'd3);
        chk("pre_outstanding", 32'(pend.size()), 32'd1);
        do_reset();
        repeat (10) drive(1, 1, 0, 0);
        chk("restart_pc", pc_at(0), RESET_PC);

        // Randomized traffic.
        do_reset();
        for (int s = 0; s < 4; s++) begin
            lat = (s == 3) ? 2 : s + 1;
            for (int i = 0; i < 500; i++) begin
                drive($urandom_range(0, 99) < rpct[s],
                      $urandom_range(0, 99) < ipct[s],
                      $urandom_range(0, 99) < 6,
                      pick_target());
            end
        end
        chk("rand_progress", 32'(hs_pcs.size() >= 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
